// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin memory-port arbiter.
// Provides the read opcode, default parameter values and the packed-slice helper.
package arb_pkg;

    localparam int unsigned OP_READ = 0;

    localparam int unsigned DEF_NUM_CLIENTS   = 4;
    localparam int unsigned DEF_ADDR_W        = 17;
    localparam int unsigned DEF_DATA_W        = 32;
    localparam int unsigned DEF_WBEN_W        = 4;
    localparam int unsigned DEF_RD_LAT        = 1;
    localparam int unsigned DEF_FETCH_MAX_GAP = 2;

    // Low bit of client idx's field inside a packed per-client vector.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority one-hot picker.
// Ports: req (request vector), ptr (search start), grant (one-hot winner, zero
// if no request), next_ptr (winner+1 wrapped, or ptr when nothing won).
module rr_pick
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
    localparam int unsigned PTR_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [PTR_W-1:0]       next_ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CLIENTS - 1);

    // Walk from ptr with explicit wrap so non-power-of-two client counts work.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        grant    = '0;
        next_ptr = ptr;
        idx      = ptr;
        found    = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == LAST) ? '0 : idx + PTR_W'(1);
            end
            idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between NUM_CLIENTS memory clients and one single-port BRAM.
// Client 0 is the pixel fetcher; optional starvation guard via ARB_FETCH_GUARD_EN.
// Ports: clk, rst_ (async active-low); req_rts/req_rtr handshake per client;
// req_addr/req_wrdata/req_op packed per client; wben/mem_addr/mem_data_out to
// the BRAM; mem_data_in from the BRAM; bcast_data/bcast_xfc read-return broadcast.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS   = DEF_NUM_CLIENTS,
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned WBEN_W        = DEF_WBEN_W,
    parameter int unsigned RD_LAT        = DEF_RD_LAT,
    parameter int unsigned FETCH_MAX_GAP = DEF_FETCH_MAX_GAP
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NUM_CLIENTS-1:0]        req_rts,
    output logic [NUM_CLIENTS-1:0]        req_rtr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wrdata,
    input  logic [NUM_CLIENTS*WBEN_W-1:0] req_op,
    output logic [WBEN_W-1:0]             wben,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_out,
    input  logic [DATA_W-1:0]             mem_data_in,
    output logic [DATA_W-1:0]             bcast_data,
    output logic [NUM_CLIENTS-1:0]        bcast_xfc
);

    localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

    if (NUM_CLIENTS < 2 || RD_LAT < 1 || FETCH_MAX_GAP < 1) begin : g_bad_param
        $error("mem_arbiter_rr: NUM_CLIENTS>=2, RD_LAT>=1, FETCH_MAX_GAP>=1 required");
    end

    logic [NUM_CLIENTS-1:0]             rtr_q, rtr_d;
    logic [PTR_W-1:0]                   ptr_q, ptr_d;
    logic [NUM_CLIENTS-1:0]             pick_grant;
    logic [PTR_W-1:0]                   pick_ptr;
    logic [NUM_CLIENTS-1:0]             xfc;
    logic [WBEN_W-1:0]                  wben_q, wben_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic [RD_LAT:0][NUM_CLIENTS-1:0]   tag_q, tag_d;
    logic [NUM_CLIENTS-1:0]             tag_push;
    logic [WBEN_W-1:0]                  sel_op;
    logic [ADDR_W-1:0]                  sel_addr;
    logic [DATA_W-1:0]                  sel_wdata;

    rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
        .req      (req_rts),
        .ptr      (ptr_q),
        .grant    (pick_grant),
        .next_ptr (pick_ptr)
    );

    assign xfc = rtr_q & req_rts;

`ifdef ARB_FETCH_GUARD_EN
    localparam int unsigned GAP_W = $clog2(FETCH_MAX_GAP + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // Arbitration: round-robin pick, optionally overridden to protect client 0.
    always_comb begin
        rtr_d = pick_grant;
        ptr_d = pick_ptr;
`ifdef ARB_FETCH_GUARD_EN
        gap_d = gap_q;
        if (req_rts[0] && gap_q == GAP_W'(FETCH_MAX_GAP - 1)) begin
            rtr_d = NUM_CLIENTS'(1);
            ptr_d = ptr_q;
        end
        if (!req_rts[0] || rtr_d[0]) begin
            gap_d = '0;
        end else if (gap_q != GAP_W'(FETCH_MAX_GAP)) begin
            gap_d = gap_q + GAP_W'(1);
        end
`endif
    end

    // Select the transferring client's request fields (xfc is at most one-hot).
    always_comb begin
        sel_op    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (xfc[i]) begin
                sel_op    = req_op[slice_lo(i, WBEN_W) +: WBEN_W];
                sel_addr  = req_addr[slice_lo(i, ADDR_W) +: ADDR_W];
                sel_wdata = req_wrdata[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    // BRAM port: wben pulses for one cycle per write; address/data hold otherwise.
    always_comb begin
        wben_d   = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_push = '0;
        if (|xfc) begin
            wben_d  = sel_op;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            if (sel_op == WBEN_W'(OP_READ)) begin
                tag_push = xfc;
            end
        end
        tag_d = {tag_q[RD_LAT-1:0], tag_push};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rtr_q   <= '0;
            ptr_q   <= '0;
            wben_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
        end else begin
            rtr_q   <= rtr_d;
            ptr_q   <= ptr_d;
            wben_q  <= wben_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
        end
    end

`ifdef ARB_FETCH_GUARD_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign req_rtr      = rtr_q;
    assign wben         = wben_q;
    assign mem_addr     = addr_q;
    assign mem_data_out = wdata_q;
    assign bcast_xfc    = tag_q[RD_LAT];
    assign bcast_data   = mem_data_in;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr (default parameters, RD_LAT=1).
// Read returns are checked by a scoreboard fed from observed transfers.
module tb_mem_arbiter_rr;
    import arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 4;

    logic            clk = 1'b0;
    logic            rst_;
    logic [N-1:0]    req_rts;
    logic [N-1:0]    req_rtr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wrdata;
    logic [N*WW-1:0] req_op;
    logic [WW-1:0]   wben;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_out;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   bcast_data;
    logic [N-1:0]    bcast_xfc;

    logic [AW-1:0] c_addr [N];
    logic [DW-1:0] c_data [N];
    logic [WW-1:0] c_op   [N];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct packed {
        logic [N-1:0]  tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]   = c_addr[i];
            req_wrdata[i*DW +: DW] = c_data[i];
            req_op[i*WW +: WW]     = c_op[i];
        end
    end

    mem_arbiter_rr dut (
        .clk          (clk),
        .rst_         (rst_),
        .req_rts      (req_rts),
        .req_rtr      (req_rtr),
        .req_addr     (req_addr),
        .req_wrdata   (req_wrdata),
        .req_op       (req_op),
        .wben         (wben),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .bcast_data   (bcast_data),
        .bcast_xfc    (bcast_xfc)
    );

    // BRAM model: fixed per-address contents, one-cycle registered read.
    function automatic logic [DW-1:0] bram_val(input logic [AW-1:0] a);
        if (a == 17'h00010) return 32'hDEADBEEF;
        return 32'hC0DE_0000 ^ DW'(a);
    endfunction

    always @(posedge clk) mem_data_in <= bram_val(mem_addr);

    // Scoreboard: push on each read transfer, pop on each broadcast return.
    always @(negedge clk) begin : sb_mon
        logic [N-1:0] x;
        exp_t         e;
        cyc = cyc + 1;
        if (!rst_) begin
            sb_q.delete();
        end else begin
            x = req_rtr & req_rts;
            for (int i = 0; i < N; i++) begin
                if (x[i] && c_op[i] == 4'h0) begin
                    e.tag  = N'(1) << i;
                    e.data = bram_val(c_addr[i]);
                    e.due  = cyc + 2;
                    sb_q.push_back(e);
                end
            end
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                compared++;
                mismatched++;
                $display("FAIL sb_missing: no bcast_xfc at cycle %0d, required tag %b", e.due, e.tag);
            end
            if (bcast_xfc != '0) begin
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_unexpected: bcast_xfc=%b at cycle %0d, required none", bcast_xfc, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (bcast_xfc !== e.tag || bcast_data !== e.data || e.due != cyc) begin
                        mismatched++;
                        $display("FAIL sb_return: tag=%b data=%h cyc=%0d, required tag=%b data=%h cyc=%0d",
                                 bcast_xfc, bcast_data, cyc, e.tag, e.data, e.due);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_    = 1'b0;
        req_rts = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = AW'(17'h00100 + i);
            c_data[i] = 32'h1111_1111 * (i + 1);
            c_op[i]   = WW'(i + 1);
        end
        repeat (3) @(posedge clk);
        #1 rst_ = 1'b1;
    endtask

    task automatic wait_xfc(input int c, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (req_rtr[c] && req_rts[c]) ok = 1'b1;
        end
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL xfc_timeout: client %0d got no transfer in 20 cycles, required one", c);
        end
    endtask

    task automatic test_reset();
        rst_    = 1'b0;
        req_rts = '0;
        @(negedge clk);
        compared++;
        if (req_rtr !== '0 || wben !== '0 || mem_addr !== '0 || mem_data_out !== '0 || bcast_xfc !== '0) begin
            mismatched++;
            $display("FAIL reset_vals: rtr=%b wben=%h addr=%h dout=%h bx=%b, required all zero",
                     req_rtr, wben, mem_addr, mem_data_out, bcast_xfc);
        end
    endtask

    task automatic test_round_robin();
        int seq [5];
        int pc;
`ifdef ARB_FETCH_GUARD_EN
        seq = '{0, 1, 0, 2, 0};
`else
        seq = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        req_rts = 4'hF;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            compared++;
            if (req_rtr !== N'(1) << seq[k]) begin
                mismatched++;
                $display("FAIL rr_grant[%0d]: rtr=%b, required %b", k, req_rtr, N'(1) << seq[k]);
            end
            if (k > 0) begin
                pc = seq[k-1];
                compared++;
                if (wben !== c_op[pc] || mem_addr !== c_addr[pc] || mem_data_out !== c_data[pc]) begin
                    mismatched++;
                    $display("FAIL rr_port[%0d]: wben=%h addr=%h dout=%h, required %h %h %h",
                             k, wben, mem_addr, mem_data_out, c_op[pc], c_addr[pc], c_data[pc]);
                end
            end
            @(posedge clk); #1;
        end
        req_rts = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_read_return();
        bit ok;
        do_reset();
        c_addr[2] = 17'h00010;
        c_op[2]   = 4'h0;
        req_rts   = 4'b0100;
        wait_xfc(2, ok);
        @(posedge clk); #1 req_rts = '0;
        @(negedge clk);
        compared++;
        if (bcast_xfc !== '0 || wben !== '0 || mem_addr !== 17'h00010) begin
            mismatched++;
            $display("FAIL rd_issue: bx=%b wben=%h addr=%h, required 0000 0 00010", bcast_xfc, wben, mem_addr);
        end
        @(negedge clk);
        compared++;
        if (bcast_xfc !== 4'b0100 || bcast_data !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL rd_return: bx=%b data=%h, required 0100 deadbeef", bcast_xfc, bcast_data);
        end
        @(negedge clk);
        compared++;
        if (bcast_xfc !== '0) begin
            mismatched++;
            $display("FAIL rd_single: bx=%b, required 0000", bcast_xfc);
        end
    endtask

    task automatic test_single_write();
        bit ok;
        do_reset();
        c_addr[1] = 17'h00055;
        c_data[1] = 32'hCAFEF00D;
        c_op[1]   = 4'hF;
        req_rts   = 4'b0010;
        wait_xfc(1, ok);
        @(posedge clk); #1 req_rts = '0;
        @(negedge clk);
        compared++;
        if (wben !== 4'hF || mem_addr !== 17'h00055 || mem_data_out !== 32'hCAFEF00D) begin
            mismatched++;
            $display("FAIL wr_pulse: wben=%h addr=%h dout=%h, required f 00055 cafef00d", wben, mem_addr, mem_data_out);
        end
        @(negedge clk);
        compared++;
        if (wben !== '0 || mem_addr !== 17'h00055) begin
            mismatched++;
            $display("FAIL wr_once: wben=%h addr=%h, required 0 00055", wben, mem_addr);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            compared++;
            if (bcast_xfc !== '0) begin
                mismatched++;
                $display("FAIL wr_no_bcast[%0d]: bx=%b, required 0000", t, bcast_xfc);
            end
        end
    endtask

    task automatic test_drop_grant();
        do_reset();
        c_addr[1] = 17'h000AA;
        c_op[1]   = 4'h1;
        c_addr[3] = 17'h01333;
        c_op[3]   = 4'h3;
        req_rts   = 4'b0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_rts = 4'b1000;
        @(posedge clk); #1;
        req_rts = '0;
        @(negedge clk);
        compared++;
        if (req_rtr !== 4'b1000 || wben !== '0) begin
            mismatched++;
            $display("FAIL drop_grant: rtr=%b wben=%h, required 1000 0", req_rtr, wben);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (wben !== '0 || mem_addr !== 17'h000AA || req_rtr !== '0) begin
            mismatched++;
            $display("FAIL drop_nowrite: wben=%h addr=%h rtr=%b, required 0 000aa 0000", wben, mem_addr, req_rtr);
        end
        req_rts = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (req_rtr !== 4'b0001) begin
            mismatched++;
            $display("FAIL drop_ptr: rtr=%b, required 0001", req_rtr);
        end
        @(posedge clk); #1 req_rts = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fairness();
        int last [N];
        int maxg [N];
        int bound [N];
        int onehot_err;
`ifdef ARB_FETCH_GUARD_EN
        bound = '{2, 6, 6, 6};
`else
        bound = '{4, 4, 4, 4};
`endif
        onehot_err = 0;
        for (int i = 0; i < N; i++) begin
            last[i] = -1;
            maxg[i] = 0;
        end
        do_reset();
        req_rts = 4'hF;
        @(posedge clk); #1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (!$onehot(req_rtr)) onehot_err++;
            for (int i = 0; i < N; i++) begin
                if (req_rtr[i]) begin
                    if (k - last[i] > maxg[i]) maxg[i] = k - last[i];
                    last[i] = k;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (23 - last[i] > maxg[i]) maxg[i] = 23 - last[i];
            compared++;
            if (maxg[i] > bound[i]) begin
                mismatched++;
                $display("FAIL fair_gap[%0d]: max gap %0d cycles, required <= %0d", i, maxg[i], bound[i]);
            end
        end
        compared++;
        if (onehot_err != 0) begin
            mismatched++;
            $display("FAIL fair_onehot: %0d non-one-hot grants, required 0", onehot_err);
        end
        @(posedge clk); #1 req_rts = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        c_addr[0] = 17'h00020;
        c_op[0]   = 4'h0;
        c_addr[1] = 17'h00021;
        c_op[1]   = 4'h0;
        req_rts   = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_rts = 4'b0010;
        @(negedge clk);
        #1 rst_ = 1'b0;
        #1;
        compared++;
        if (req_rtr !== '0 || wben !== '0 || mem_addr !== '0 || mem_data_out !== '0 || bcast_xfc !== '0) begin
            mismatched++;
            $display("FAIL inflight_reset: rtr=%b wben=%h addr=%h dout=%h bx=%b, required all zero",
                     req_rtr, wben, mem_addr, mem_data_out, bcast_xfc);
        end
        req_rts = '0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            compared++;
            if (bcast_xfc !== '0) begin
                mismatched++;
                $display("FAIL inflight_discard[%0d]: bx=%b, required 0000", t, bcast_xfc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0;
            c_data[i] = '0;
            c_op[i]   = '0;
        end
        test_reset();
        test_round_robin();
        test_read_return();
        test_single_write();
        test_drop_grant();
        test_fairness();
        test_reset_inflight();
        repeat (4) @(negedge clk);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: %0d returns outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised memory-port arbiter between N requesting clients (client 0 is the pixel fetcher, the others are draw engines) and a single-port BRAM. It grants one client per cycle with rotating round-robin priority and an optional starvation guard for client 0. It registers the winning request onto the BRAM port and routes read data back to the requester with a configurable read latency. It replaces the fixed three-client arbiter in the graphics engine memory path.

## Interface
- NUM_CLIENTS, 4, number of clients (>=2); bit i of every vector belongs to client i
- ADDR_W, 17, memory address width
- DATA_W, 32, data width
- WBEN_W, 4, byte write-enable width; op value 0 means read
- RD_LAT, 1, BRAM cycles from registered address to valid mem_data_in (>=1)
- FETCH_MAX_GAP, 2, maximum cycles client 0 waits for a grant while requesting (>=1)

- clk  input  1  clock, rising edge
- rst_  input  1  asynchronous active-low reset
- req_rts  input  NUM_CLIENTS  client ready-to-send
- req_rtr  output  NUM_CLIENTS  registered one-hot grant (ready-to-receive)
- req_addr  input  NUM_CLIENTS*ADDR_W  packed client addresses
- req_wrdata  input  NUM_CLIENTS*DATA_W  packed client write data
- req_op  input  NUM_CLIENTS*WBEN_W  packed client byte enables / op
- wben  output  WBEN_W  BRAM byte write enables
- mem_addr  output  ADDR_W  BRAM address
- mem_data_out  output  DATA_W  BRAM write data
- mem_data_in  input  DATA_W  BRAM read data
- bcast_data  output  DATA_W  read-back data, combinational copy of mem_data_in
- bcast_xfc  output  NUM_CLIENTS  one-hot read-return strobe

## Operation
- Transfer: xfc[i] = req_rtr[i] & req_rts[i]. A client holds rts, addr, wrdata and op stable until it sees xfc.
- Arbitration runs every cycle on the current req_rts. The result is registered into req_rtr, so there is a one-cycle grant latency. req_rtr is all-zero when nothing is requested.
- Round-robin: search starts at pointer ptr, wrapping at NUM_CLIENTS-1 to 0. The winner w sets ptr to (w+1) mod NUM_CLIENTS. ptr is unchanged when there is no winner.
- Grant to a client whose rts has dropped is wasted: no transfer and no state change except ptr.
- On xfc[i] the next edge sets wben, mem_addr and mem_data_out from client i. With no xfc, wben is 0 (a write never repeats); mem_addr and mem_data_out hold.
- Read return: an xfc with op==0 pushes one-hot i into a tag shift pipe of depth RD_LAT+1. Writes push zero. The pipe output drives bcast_xfc.
- Back-to-back grants to the same client are allowed.

## Timing
- Reset values: req_rtr=0, wben=0, mem_addr=0, mem_data_out=0, bcast_xfc=0, ptr=0, gap counter=0, tag pipe cleared.
- Cycle T: req_rts[i] high. T+1: req_rtr[i] high, and xfc if rts is still high. T+2: wben, mem_addr and mem_data_out valid. T+2+RD_LAT: bcast_xfc[i]=1 with bcast_data valid.
- Read-issue to bcast_xfc latency is fixed at RD_LAT+1 cycles from xfc. One read return per cycle maximum; returns come in issue order.
- Reset asserted mid-operation: in-flight reads are discarded and produce no bcast_xfc after reset release. The first grant can appear 1 cycle after release.

## Configuration
- ARB_FETCH_GUARD_EN defined:
  - A gap counter of width $clog2(FETCH_MAX_GAP+1) increments each cycle that req_rts[0] is high and client 0 is not granted.
  - The counter clears on grant to 0 or when req_rts[0] is low.
  - When req_rts[0] is high and the counter is FETCH_MAX_GAP-1, the next grant is forced to client 0 and ptr is not advanced.
  - FETCH_MAX_GAP=1 means client 0 wins every cycle it requests.
- Undefined: pure round-robin; the counter logic is absent.

## Structure
- Package arb_pkg: OP_READ constant (0), a default-width localparam for each parameter, and a packed-slice helper function for client i.
- Sub-module rr_pick: combinational rotating-priority one-hot picker with inputs req and ptr, and outputs grant and next_ptr. Parametrised by NUM_CLIENTS.

## Test plan
- Reset then rts=4'b1111 held, guard off -> req_rtr sequence 0001, 0010, 0100, 1000, 0001; each wben/mem_addr matches that client one cycle later.
- Client 2 reads addr 0x00010 with RD_LAT=1, BRAM model returns 0xDEADBEEF -> bcast_xfc=4'b0100 exactly 2 cycles after xfc with bcast_data=0xDEADBEEF; no other bcast bits set.
- Client 1 writes op=4'hF once then drops rts -> wben=4'hF for exactly one cycle, then 0; bcast_xfc stays 0.
- Guard on, FETCH_MAX_GAP=2, all clients requesting continuously -> client 0 granted at least every 2nd cycle; clients 1-3 each granted within 6 cycles.
- Client 3 granted but drops rts in the grant cycle -> no write, wben=0, ptr advanced to 0.
- Issue reads from clients 0 and 1 back-to-back, then assert rst_=0 before return -> all outputs return to reset values; no bcast_xfc after release.
